// File: rtl/hwpe_ctrl_regfile_pkg.sv
// Shared types and helpers for the multi-port HWPE control register file.
// Optional per-byte parity is enabled with HWPE_CTRL_REGFILE_PARITY_EN.
package hwpe_ctrl_regfile_pkg;

  localparam int MAX_RPORTS = 4;

  typedef enum logic {
    IDLE,
    CLEAR
  } regfile_clr_state_e;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_regfile_rport.sv
// One registered read port with write-first bypass of the in-flight write.
// With HWPE_CTRL_REGFILE_PARITY_EN it also flags stored-parity mismatches.
module hwpe_ctrl_regfile_rport
  import hwpe_ctrl_regfile_pkg::*;
#(
  parameter int NUM_WORDS   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WRITE_FIRST = 1,
  parameter int ADDR_WIDTH  = $clog2(NUM_WORDS),
  parameter int NUM_BYTE    = DATA_WIDTH / 8
) (
`ifdef HWPE_CTRL_REGFILE_PARITY_EN
  input  logic [NUM_WORDS-1:0][NUM_BYTE-1:0]   par,
  output logic                                 perr,
`endif
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem,
  input  logic                                 clr_zero,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [NUM_BYTE-1:0][7:0]             wr_data,
  input  logic [NUM_BYTE-1:0]                  wr_be,
  output logic [DATA_WIDTH-1:0]                data,
  output logic                                 valid
);

  logic                     hit;
  logic [NUM_BYTE-1:0]      byp;
  logic [NUM_BYTE-1:0][7:0] word;

  always_comb begin
    hit  = 32'(addr) < NUM_WORDS;
    byp  = '0;
    word = '0;
    if (hit) word = mem[addr];
    if (WRITE_FIRST != 0 && wr_en && wr_addr == addr) byp = wr_be;
    for (int j = 0; j < NUM_BYTE; j++)
      if (byp[j]) word[j] = wr_data[j];
    // a same-cycle single-shot clear reads back as zero
    if (WRITE_FIRST != 0 && clr_zero) word = '0;
  end

`ifdef HWPE_CTRL_REGFILE_PARITY_EN
  logic err;

  always_comb begin
    err = 1'b0;
    if (hit && !(WRITE_FIRST != 0 && clr_zero))
      for (int j = 0; j < NUM_BYTE; j++)
        if (!byp[j] &&
            par[addr][j] != byte_parity(mem[addr][j*8 +: 8]))
          err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) perr <= 1'b0;
    else     perr <= en && err;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) data <= word;
    end
  end

endmodule

// File: rtl/hwpe_ctrl_regfile_mp.sv
// Flip-flop regfile: N registered read ports, byte-enabled write, clear.
// Optional per-byte parity is enabled with HWPE_CTRL_REGFILE_PARITY_EN.
module hwpe_ctrl_regfile_mp
  import hwpe_ctrl_regfile_pkg::*;
#(
  parameter int NUM_WORDS   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_RPORTS  = 2,
  parameter int CLEAR_SWEEP = 0,
  parameter int WRITE_FIRST = 1,
  parameter int ADDR_WIDTH  = $clog2(NUM_WORDS),
  parameter int NUM_BYTE    = DATA_WIDTH / 8
) (
`ifdef HWPE_CTRL_REGFILE_PARITY_EN
  input  logic                                  force_parity_flip,
  output logic [NUM_RPORTS-1:0]                 parity_err,
`endif
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  output logic                                  busy,
  input  logic [NUM_RPORTS-1:0]                 ReadEnable,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] ReadAddr,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] ReadData,
  output logic [NUM_RPORTS-1:0]                 ReadValid,
  input  logic                                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                 WriteAddr,
  input  logic [NUM_BYTE-1:0][7:0]              WriteData,
  input  logic [NUM_BYTE-1:0]                   WriteBE,
  output logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  MemContent
);

  regfile_clr_state_e                   state;
  logic [ADDR_WIDTH-1:0]                cnt;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem;
  logic                                 in_clear;
  logic                                 clr_all;
  logic                                 wr_ok;
  logic [NUM_RPORTS-1:0]                rd_en;

  assign in_clear = state == CLEAR;
  assign clr_all  = CLEAR_SWEEP == 0 && clear;
  assign wr_ok    = WriteEnable && !in_clear && !clear &&
                    32'(WriteAddr) < NUM_WORDS;
  assign rd_en    = ReadEnable & {NUM_RPORTS{!in_clear}};
  assign MemContent = mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (CLEAR_SWEEP != 0) begin
      unique case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear) begin
            cnt <= '0;
          end else if (cnt == ADDR_WIDTH'(NUM_WORDS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      mem <= '0;
    end else if (in_clear) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      for (int j = 0; j < NUM_BYTE; j++)
        if (WriteBE[j]) mem[WriteAddr][j*8 +: 8] <= WriteData[j];
    end
  end

`ifdef HWPE_CTRL_REGFILE_PARITY_EN
  logic [NUM_WORDS-1:0][NUM_BYTE-1:0] par;

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      par <= '0;
    end else if (in_clear) begin
      par[cnt] <= '0;
    end else if (wr_ok) begin
      for (int j = 0; j < NUM_BYTE; j++)
        if (WriteBE[j])
          par[WriteAddr][j] <= byte_parity(WriteData[j]) ^ force_parity_flip;
    end
  end
`endif

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    hwpe_ctrl_regfile_rport #(
      .NUM_WORDS   (NUM_WORDS),
      .DATA_WIDTH  (DATA_WIDTH),
      .WRITE_FIRST (WRITE_FIRST),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .NUM_BYTE    (NUM_BYTE)
    ) u_rport (
`ifdef HWPE_CTRL_REGFILE_PARITY_EN
      .par      (par),
      .perr     (parity_err[p]),
`endif
      .clk      (clk),
      .rst      (rst),
      .en       (rd_en[p]),
      .addr     (ReadAddr[p]),
      .mem      (mem),
      .clr_zero (clr_all),
      .wr_en    (wr_ok),
      .wr_addr  (WriteAddr),
      .wr_data  (WriteData),
      .wr_be    (WriteBE),
      .data     (ReadData[p]),
      .valid    (ReadValid[p])
    );
  end

endmodule

// File: tb/tb_hwpe_ctrl_regfile_mp.sv
// Bench: two regfile builds (single-shot/write-first, swept/read-first)
// checked against an array-level reference model.
module tb_hwpe_ctrl_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // build A: 20 words, single-cycle clear, write-first
  logic              a_clear, a_busy, a_we;
  logic [1:0]        a_re, a_rv;
  logic [1:0][4:0]   a_ra;
  logic [1:0][31:0]  a_rd;
  logic [4:0]        a_wa;
  logic [3:0][7:0]   a_wd;
  logic [3:0]        a_be;
  logic [19:0][31:0] a_mem;

  // build B: 8 words, swept clear, read-first
  logic              b_clear, b_busy, b_we;
  logic [1:0]        b_re, b_rv;
  logic [1:0][2:0]   b_ra;
  logic [1:0][31:0]  b_rd;
  logic [2:0]        b_wa;
  logic [3:0][7:0]   b_wd;
  logic [3:0]        b_be;
  logic [7:0][31:0]  b_mem;

`ifdef HWPE_CTRL_REGFILE_PARITY_EN
  logic       a_fpf, b_fpf;
  logic [1:0] a_perr, b_perr;
`endif

  hwpe_ctrl_regfile_mp #(
    .NUM_WORDS(20), .DATA_WIDTH(32), .NUM_RPORTS(2),
    .CLEAR_SWEEP(0), .WRITE_FIRST(1)
  ) dut_a (
`ifdef HWPE_CTRL_REGFILE_PARITY_EN
    .force_parity_flip(a_fpf), .parity_err(a_perr),
`endif
    .clk(clk), .rst(rst), .clear(a_clear), .busy(a_busy),
    .ReadEnable(a_re), .ReadAddr(a_ra), .ReadData(a_rd),
    .ReadValid(a_rv), .WriteEnable(a_we), .WriteAddr(a_wa),
    .WriteData(a_wd), .WriteBE(a_be), .MemContent(a_mem)
  );

  hwpe_ctrl_regfile_mp #(
    .NUM_WORDS(8), .DATA_WIDTH(32), .NUM_RPORTS(2),
    .CLEAR_SWEEP(1), .WRITE_FIRST(0)
  ) dut_b (
`ifdef HWPE_CTRL_REGFILE_PARITY_EN
    .force_parity_flip(b_fpf), .parity_err(b_perr),
`endif
    .clk(clk), .rst(rst), .clear(b_clear), .busy(b_busy),
    .ReadEnable(b_re), .ReadAddr(b_ra), .ReadData(b_rd),
    .ReadValid(b_rv), .WriteEnable(b_we), .WriteAddr(b_wa),
    .WriteData(b_wd), .WriteBE(b_be), .MemContent(b_mem)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] ma [20];
  logic [31:0] mb [8];
  logic [31:0] ea_rd [2];
  logic [31:0] eb_rd [2];
  logic [1:0]  ea_rv, eb_rv;
  bit          b_act;
  int          b_pos;

  task automatic chk(input string tag, input logic [1023:0] got,
                     input logic [1023:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] be);
    for (int j = 0; j < 4; j++)
      if (be[j]) o[j*8 +: 8] = n[j*8 +: 8];
    return o;
  endfunction

  function automatic logic [639:0] pack_a();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = ma[i];
    return r;
  endfunction

  function automatic logic [255:0] pack_b();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = mb[i];
    return r;
  endfunction

  task automatic idle();
    a_clear = 0; a_we = 0; a_re = '0;
    b_clear = 0; b_we = 0; b_re = '0;
`ifdef HWPE_CTRL_REGFILE_PARITY_EN
    a_fpf = 0; b_fpf = 0;
`endif
  endtask

  // advance the model over the coming edge, clock it, compare everything
  task automatic tick();
    bit          wok;
    logic [31:0] v;
    if (rst) begin
      for (int i = 0; i < 20; i++) ma[i] = '0;
      for (int i = 0; i < 8; i++) mb[i] = '0;
      for (int p = 0; p < 2; p++) begin
        ea_rd[p] = '0; eb_rd[p] = '0;
      end
      ea_rv = '0; eb_rv = '0; b_act = 0; b_pos = 0;
    end else begin
      wok = a_we && a_wa < 20 && !a_clear;
      for (int p = 0; p < 2; p++) begin
        ea_rv[p] = a_re[p];
        if (a_re[p]) begin
          if (a_ra[p] >= 20 || a_clear) ea_rd[p] = '0;
          else begin
            v = ma[a_ra[p]];
            if (wok && a_wa == a_ra[p]) v = merge(v, a_wd, a_be);
            ea_rd[p] = v;
          end
        end
      end
      if (a_clear) for (int i = 0; i < 20; i++) ma[i] = '0;
      else if (wok) ma[a_wa] = merge(ma[a_wa], a_wd, a_be);
      if (b_act) begin
        eb_rv = '0;
        mb[b_pos] = '0;
        if (b_clear) b_pos = 0;
        else if (b_pos == 7) b_act = 0;
        else b_pos++;
      end else begin
        for (int p = 0; p < 2; p++) begin
          eb_rv[p] = b_re[p];
          if (b_re[p]) eb_rd[p] = mb[b_ra[p]];
        end
        if (b_we && !b_clear) mb[b_wa] = merge(mb[b_wa], b_wd, b_be);
        if (b_clear) begin
          b_act = 1; b_pos = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk("a_valid", 1024'(a_rv[p]), 1024'(ea_rv[p]));
      chk("a_data",  1024'(a_rd[p]), 1024'(ea_rd[p]));
      chk("b_valid", 1024'(b_rv[p]), 1024'(eb_rv[p]));
      chk("b_data",  1024'(b_rd[p]), 1024'(eb_rd[p]));
    end
    chk("a_busy", 1024'(a_busy), 1024'(0));
    chk("b_busy", 1024'(b_busy), 1024'(b_act));
    chk("a_mem", 1024'(a_mem), 1024'(pack_a()));
    chk("b_mem", 1024'(b_mem), 1024'(pack_b()));
  endtask

  task automatic fill_b();
    for (int i = 0; i < 8; i++) begin
      idle();
      b_we = 1; b_wa = 3'(i); b_be = 4'hf;
      b_wd = 32'h0101_0000 | 32'($urandom_range(1, 65535));
      tick();
    end
    idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!b_busy) break;
      n++;
      b_we = 1; b_wa = 3'd2; b_wd = 32'hFFFF_FFFF; b_be = 4'hf;
      tick();
    end
    idle();
  endtask

  initial begin
    int n;
    rst = 1;
    a_ra = '0; a_wa = '0; a_wd = '0; a_be = '0;
    b_ra = '0; b_wa = '0; b_wd = '0; b_be = '0;
    idle();
    tick();
    chk("rst_a_valid", 1024'(a_rv), 1024'(0));
    chk("rst_b_busy", 1024'(b_busy), 1024'(0));
    rst = 0;

    // basic write then read
    a_we = 1; a_wa = 5; a_wd = 32'hDEAD_BEEF; a_be = 4'hf;
    tick();
    idle();
    a_re[0] = 1; a_ra[0] = 5;
    tick();
    chk("t1_valid", 1024'(a_rv[0]), 1024'(1));
    chk("t1_data", 1024'(a_rd[0]), 1024'(32'hDEAD_BEEF));

    // collision: partial byte write with same-cycle read
    idle();
    a_we = 1; a_wa = 3; a_wd = 32'hAAAA_AAAA; a_be = 4'hf;
    b_we = 1; b_wa = 3; b_wd = 32'hAAAA_AAAA; b_be = 4'hf;
    tick();
    a_wd = 32'h1122_3344; a_be = 4'b0101;
    b_wd = 32'h1122_3344; b_be = 4'b0101;
    a_re[1] = 1; a_ra[1] = 3;
    b_re[1] = 1; b_ra[1] = 3;
    tick();
    chk("t2_a_bypass", 1024'(a_rd[1]), 1024'(32'hAA22_AA44));
    chk("t2_b_old", 1024'(b_rd[1]), 1024'(32'hAAAA_AAAA));
    idle();
    a_re[1] = 1; b_re[1] = 1;
    tick();
    chk("t2_a_later", 1024'(a_rd[1]), 1024'(32'hAA22_AA44));
    chk("t2_b_later", 1024'(b_rd[1]), 1024'(32'hAA22_AA44));

    // out-of-range write and read on the 20-word build
    idle();
    a_we = 1; a_wa = 25; a_wd = 32'h1234_5678; a_be = 4'hf;
    tick();
    idle();
    a_re[0] = 1; a_ra[0] = 25;
    tick();
    chk("t3_valid", 1024'(a_rv[0]), 1024'(1));
    chk("t3_data", 1024'(a_rd[0]), 1024'(0));

    // swept clear; writes during busy are lost
    fill_b();
    b_clear = 1; b_we = 1; b_wa = 1; b_wd = 32'h5555_5555; b_be = 4'hf;
    tick();
    idle();
    count_busy(n);
    chk("t4_busy_len", 1024'(n), 1024'(8));
    chk("t4_zero", 1024'(b_mem), 1024'(0));

    // restart mid-sweep
    fill_b();
    b_clear = 1;
    tick();
    idle();
    repeat (4) tick();
    b_clear = 1;
    tick();
    idle();
    count_busy(n);
    chk("t5_restart_len", 1024'(n), 1024'(8));

    // reset mid-sweep
    fill_b();
    b_clear = 1;
    tick();
    idle();
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_busy", 1024'(b_busy), 1024'(0));
    chk("t5_rst_zero", 1024'(b_mem), 1024'(0));

`ifdef HWPE_CTRL_REGFILE_PARITY_EN
    idle();
    a_we = 1; a_wa = 2; a_wd = 32'h0F0F_1234; a_be = 4'hf; a_fpf = 1;
    tick();
    idle();
    a_re[0] = 1; a_ra[0] = 2;
    tick();
    chk("par_err", 1024'(a_perr[0]), 1024'(1));
    idle();
    a_we = 1; a_wa = 2; a_wd = 32'h0F0F_1234; a_be = 4'hf;
    tick();
    idle();
    a_re[0] = 1; a_ra[0] = 2;
    tick();
    chk("par_ok", 1024'(a_perr[0]), 1024'(0));
`endif

    // randomized traffic on both builds
    for (int c = 0; c < 800; c++) begin
      idle();
      rst = ($urandom % 250) == 0;
      a_re = 2'($urandom);
      b_re = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        a_ra[p] = 5'($urandom_range(0, 23));
        b_ra[p] = 3'($urandom);
      end
      a_we = 1'($urandom); a_wa = 5'($urandom_range(0, 23));
      a_wd = $urandom; a_be = 4'($urandom);
      b_we = 1'($urandom); b_wa = 3'($urandom);
      b_wd = $urandom; b_be = 4'($urandom);
      a_clear = ($urandom % 40) == 0;
      b_clear = ($urandom % 60) == 0;
      tick();
    end
    rst = 0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_regfile_mp.md
Name: hwpe_ctrl_regfile_mp

Overview:
- Flip-flop register file for HWPE control slaves; successor to the single-port latch/FF regfile.
- Generalised to a non-power-of-two depth, N independent registered read ports and a byte-enabled write port.
- Adds write-first bypass and a selectable single-cycle or swept (one word per cycle) clear, with a busy flag.
- Sits between the peripheral-bus slave and the job/context register logic of hwpe_ctrl.

Parameters:
- NUM_WORDS, 32, number of words; any value >= 2.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- NUM_RPORTS, 2, number of read ports (1..4).
- CLEAR_SWEEP, 0, 0 = clear in one cycle; 1 = clear one word per cycle.
- WRITE_FIRST, 1, 1 = same-cycle write data is bypassed to the reading port.
- ADDR_WIDTH, $clog2(NUM_WORDS), derived; do not override.
- NUM_BYTE, DATA_WIDTH/8, derived.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  reset: synchronous, active-high.
- clear  in  1  start a clear of the whole array.
- busy  out  1  high while a swept clear is in progress.
- ReadEnable  in  NUM_RPORTS  per-port read request.
- ReadAddr  in  NUM_RPORTS x ADDR_WIDTH  per-port read address.
- ReadData  out  NUM_RPORTS x DATA_WIDTH  registered read data.
- ReadValid  out  NUM_RPORTS  ReadData updated this cycle.
- WriteEnable  in  1  write request.
- WriteAddr  in  ADDR_WIDTH  write address.
- WriteData  in  NUM_BYTE x 8  write data.
- WriteBE  in  NUM_BYTE  byte enables.
- MemContent  out  NUM_WORDS x DATA_WIDTH  direct array view; false path.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All words cleared to 0.
  - ReadData=0, ReadValid=0, busy=0, FSM state IDLE, sweep counter 0.
  - rst during a sweep aborts the sweep; the array is still zeroed by reset.
- Write:
  - In IDLE with WriteEnable=1 and WriteAddr<NUM_WORDS, each byte j with WriteBE[j]=1 is stored at the clk edge.
  - WriteAddr>=NUM_WORDS: write silently dropped.
  - WriteBE=0: no change to the array.
- Read:
  - Latency 1. If ReadEnable[p]=1 in cycle t, then at t+1 ReadData[p]=mem[ReadAddr[p]] as sampled at edge t, and ReadValid[p]=1.
  - Without ReadEnable, ReadValid[p]=0 and ReadData[p] holds its last value.
  - Address >= NUM_WORDS: ReadData[p]=0, ReadValid[p]=1.
  - Ports are fully independent; any set of ports may read the same address in the same cycle.
- Read/write collision (same address, same cycle):
  - WRITE_FIRST=1: enabled bytes come from WriteData, other bytes from the old word.
  - WRITE_FIRST=0: the old word is returned.
- Clear, CLEAR_SWEEP=0:
  - clear=1 zeroes all words at the edge; busy stays 0.
  - clear beats a simultaneous write.
  - A simultaneous read returns pre-clear data; with WRITE_FIRST=1 it returns 0.
- Clear, CLEAR_SWEEP=1, FSM:
  - IDLE -> CLEAR on clear=1; counter<=0; busy=1 from the next cycle.
  - CLEAR: word[counter]<=0 each cycle; counter increments; CLEAR -> IDLE after word NUM_WORDS-1 (NUM_WORDS cycles total); busy=0 in the cycle after the final word.
  - While busy: WriteEnable ignored; ReadEnable ignored (ReadValid=0).
  - clear=1 while busy restarts the counter at 0.
  - clear and write together in IDLE: the write is dropped.
- Counter width is ADDR_WIDTH and never exceeds NUM_WORDS-1.
- MemContent reflects the array combinationally from the registered storage.

Optional Feature:
- Macro: HWPE_CTRL_REGFILE_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte.
  - An added output parity_err [NUM_RPORTS] is asserted together with ReadValid when a read byte's parity mismatches.
  - Bypassed bytes compute fresh parity.
  - Clear and reset store parity 0.
  - Adds a force_parity_flip input (1 bit) that inverts the stored parity of the bytes being written, for test.
- When undefined: none of these ports or bits exist; behaviour is otherwise identical.

Decomposition:
- Package hwpe_ctrl_regfile_pkg:
  - FSM enum regfile_clr_state_e {IDLE, CLEAR}.
  - Function byte_parity.
  - Constant MAX_RPORTS=4.
- Sub-module hwpe_ctrl_regfile_rport: one registered read port containing the bypass mux; instantiated NUM_RPORTS times by a generate loop.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5 with BE=1111; read port 0 addr 5 -> ReadValid=1 one cycle later, ReadData=0xDEADBEEF.
- Write 0x11223344 to addr 3 with BE=0101 over 0xAAAAAAAA while port1 reads addr 3 in the same cycle -> 0xAA22AA44 (WRITE_FIRST=1) or 0xAAAAAAAA (WRITE_FIRST=0); a later read gives 0xAA22AA44.
- NUM_WORDS=20: write to addr 25 then read addr 25 -> write dropped, ReadData=0, MemContent unchanged.
- CLEAR_SWEEP=1, NUM_WORDS=8, all words filled: pulse clear -> busy high for 8 cycles; a write issued during busy is lost; afterwards all MemContent=0.
- Re-pulse clear at sweep cycle 4 -> the sweep restarts and busy lasts 8 more cycles; assert rst mid-sweep -> busy=0 next cycle and the array is 0.
- Parity build: write addr 2 with force_parity_flip=1, then read -> parity_err[0]=1 with ReadValid; a normal rewrite of addr 2 followed by a read -> parity_err=0.
